// File: rtl/filtre_akis_modul.sv
// Streaming 3x3 image filter: two line buffers, a 3x3 window, one arithmetic stage and a FWFT output FIFO.
// Build option FILTRE_ESIK_EN adds a latched binary threshold on each result.
module filtre_akis_modul #(
  parameter int IMG_W      = 500,
  parameter int IMG_H      = 450,
  parameter int D_BITS     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic              i_drdy,
  input  logic [D_BITS-1:0] i_data,
  output logic              o_in_rdy,
  input  logic [1:0]        i_mode,
`ifdef FILTRE_ESIK_EN
  input  logic [D_BITS-1:0] i_thresh,
  input  logic              i_thresh_on,
`endif
  input  logic              i_tx_rdy,
  output logic [D_BITS-1:0] o_data,
  output logic              o_dvalid,
  output logic              o_frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = D_BITS + 5;
  localparam logic signed [SW-1:0] MAX_S = SW'((1 << D_BITS) - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          accept, produce, last_col, last_row, first_px;
  logic          in_rdy_q, in_rdy_d;
  logic          v1_q, v2_q, frame_done_q;
  logic [1:0]    mode_q;
  logic [D_BITS-1:0] res_q, res_d;

  logic [D_BITS-1:0] lb1_q [IMG_W];
  logic [D_BITS-1:0] lb2_q [IMG_W];
  logic [D_BITS-1:0] win_q [3][3];

  logic [D_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [AW:0]       cnt_q, cnt_d;
  logic [AW+1:0]     occ_d;
  logic              push, pop;

  assign accept   = i_drdy && in_rdy_q;
  assign last_col = (col_q == CW'(IMG_W - 1));
  assign last_row = (row_q == RW'(IMG_H - 1));
  assign first_px = (col_q == '0) && (row_q == '0);
  assign produce  = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Line buffers and window carry no reset; the r>=2 / c>=2 gate masks stale contents.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      lb2_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= i_data;
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb2_q[col_q];
      win_q[1][2] <= lb1_q[col_q];
      win_q[2][2] <= i_data;
    end
  end

  logic signed [SW-1:0] p_s [3][3];
  logic signed [SW-1:0] edge_sum, gauss_sh, sharp, lap, lap_abs;

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        p_s[r][c] = $signed({5'b0, win_q[r][c]});
      end
    end
    edge_sum = p_s[0][1] + p_s[2][1] + p_s[1][0] + p_s[1][2];
    gauss_sh = ((edge_sum <<< 1) + (p_s[1][1] <<< 2)
               + p_s[0][0] + p_s[0][2] + p_s[2][0] + p_s[2][2]) >>> 4;
    sharp    = (p_s[1][1] <<< 2) + p_s[1][1] - edge_sum;
    lap      = (p_s[1][1] <<< 2) - edge_sum;
    lap_abs  = lap[SW-1] ? -lap : lap;
  end

`ifdef FILTRE_ESIK_EN
  logic [D_BITS-1:0] thr_q;
  logic              thr_on_q;
`endif

  always_comb begin
    res_d = win_q[1][1];
    case (mode_q)
      2'd1: res_d = (gauss_sh > MAX_S) ? '1 : gauss_sh[D_BITS-1:0];
      2'd2: begin
        if (sharp[SW-1])        res_d = '0;
        else if (sharp > MAX_S) res_d = '1;
        else                    res_d = sharp[D_BITS-1:0];
      end
      2'd3: res_d = (lap_abs > MAX_S) ? '1 : lap_abs[D_BITS-1:0];
      default: res_d = win_q[1][1];
    endcase
`ifdef FILTRE_ESIK_EN
    if (thr_on_q) res_d = (res_d >= thr_q) ? '1 : '0;
`endif
  end

  assign push = v2_q;
  assign pop  = (cnt_q != '0) && i_tx_rdy;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
  end

  // Next-cycle occupancy plus results still in the pipe; keeps one slot per possible accept.
  assign occ_d    = {1'b0, cnt_d} + (AW+2)'(produce) + (AW+2)'(v1_q);
  assign in_rdy_d = (occ_d <= (AW+2)'(FIFO_DEPTH - 1));

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wptr_q] <= res_q;
  end

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      col_q        <= '0;
      row_q        <= '0;
      in_rdy_q     <= 1'b1;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      res_q        <= '0;
      frame_done_q <= 1'b0;
      mode_q       <= 2'd0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
`ifdef FILTRE_ESIK_EN
      thr_q        <= '0;
      thr_on_q     <= 1'b0;
`endif
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      in_rdy_q     <= in_rdy_d;
      v1_q         <= produce;
      v2_q         <= v1_q;
      if (v1_q) res_q <= res_d;
      frame_done_q <= accept && last_col && last_row;
      if (accept && first_px) begin
        mode_q   <= i_mode;
`ifdef FILTRE_ESIK_EN
        thr_q    <= i_thresh;
        thr_on_q <= i_thresh_on;
`endif
      end
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  assign o_in_rdy     = in_rdy_q;
  assign o_dvalid     = (cnt_q != '0);
  assign o_data       = o_dvalid ? mem_q[rptr_q] : '0;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_filtre_akis_modul.sv
// Self-checking bench for filtre_akis_modul on a 5x4 frame with a 4-entry FIFO.
// Expected pixels come from a direct 3x3 neighbourhood model over the whole frame image.
module tb_filtre_akis_modul;
  localparam int W = 5, H = 4, DB = 8, FD = 4, NPIX = W * H;

  logic          i_clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_drdy = 1'b0;
  logic [DB-1:0] i_data = '0;
  logic [1:0]    i_mode = 2'd0;
  logic          i_tx_rdy = 1'b0;
  logic [DB-1:0] i_thresh = '0;
  logic          i_thresh_on = 1'b0;
  logic          o_in_rdy, o_dvalid, o_frame_done;
  logic [DB-1:0] o_data;

  filtre_akis_modul #(.IMG_W(W), .IMG_H(H), .D_BITS(DB), .FIFO_DEPTH(FD)) dut (
    .i_clk(i_clk), .reset(reset), .i_drdy(i_drdy), .i_data(i_data),
    .o_in_rdy(o_in_rdy), .i_mode(i_mode),
`ifdef FILTRE_ESIK_EN
    .i_thresh(i_thresh), .i_thresh_on(i_thresh_on),
`endif
    .i_tx_rdy(i_tx_rdy), .o_data(o_data), .o_dvalid(o_dvalid), .o_frame_done(o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0, failures = 0;
  int cyc = 0, tx_mode = 0;
  int got[$], exp_q[$];
  int acc_cnt = 0, fd_cnt = 0, first_valid_cyc = -1, acc12_cyc = 0;
  logic fd_after_last = 1'b0;
  int ramp[NPIX], img3[NPIX], flat[NPIX];

  initial forever begin @(posedge i_clk); cyc++; end

  // tx_mode: 0 ready, 1 stalled, 2 toggling, 3 random
  initial forever begin
    @(posedge i_clk); #1;
    case (tx_mode)
      0: i_tx_rdy = 1'b1;
      1: i_tx_rdy = 1'b0;
      2: i_tx_rdy = ~i_tx_rdy;
      default: i_tx_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  initial forever begin
    @(negedge i_clk);
    if (reset) begin
      if (o_dvalid && i_tx_rdy) got.push_back(int'(o_data));
      if (o_dvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (i_drdy && o_in_rdy) acc_cnt++;
      if (o_frame_done) fd_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  function automatic int px(input int img[NPIX], input int y, input int x);
    return img[y * W + x];
  endfunction

  task automatic add_expected(input int img[NPIX], input int mode, input int thr_on, input int thr);
    for (int y = 1; y < H - 1; y++) begin
      for (int x = 1; x < W - 1; x++) begin
        int c, n, s, e, w, v;
        c = px(img, y, x);     n = px(img, y - 1, x); s = px(img, y + 1, x);
        w = px(img, y, x - 1); e = px(img, y, x + 1);
        case (mode)
          0: v = c;
          1: v = (4 * c + 2 * (n + s + e + w) + px(img, y - 1, x - 1) + px(img, y - 1, x + 1)
                  + px(img, y + 1, x - 1) + px(img, y + 1, x + 1)) / 16;
          2: begin v = 5 * c - n - s - e - w; if (v < 0) v = 0; if (v > 255) v = 255; end
          default: begin v = 4 * c - n - s - e - w; if (v < 0) v = -v; if (v > 255) v = 255; end
        endcase
        if (thr_on != 0) v = (v >= thr) ? 255 : 0;
        exp_q.push_back(v);
      end
    end
  endtask

  task automatic run_frame(input int img[NPIX], input int npx, input logic [1:0] mode,
                           input bit scramble, input bit gaps);
    for (int p = 0; p < npx; p++) begin
      int waited = 0;
      bit taken = 1'b0;
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          i_drdy = 1'b0; @(posedge i_clk); #1;
        end
      end
      i_drdy = 1'b1;
      i_data = DB'(img[p]);
      i_mode = (p == 0 || !scramble) ? mode : 2'($urandom_range(0, 3));
      while (!taken) begin
        taken = o_in_rdy;
        @(posedge i_clk); #1;
        if (!taken) begin
          waited++;
          if (waited > 400) begin
            checks++; failures++;
            $display("FAIL input_stall pixel=%0d waited=%0d limit=400", p, waited);
            i_drdy = 1'b0;
            return;
          end
        end
      end
      if (p == 12) acc12_cyc = cyc;
      if (p == NPIX - 1) fd_after_last = o_frame_done;
    end
    i_drdy = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    int w = 0;
    while (got.size() < n && w < 3000) begin @(posedge i_clk); #1; w++; end
    repeat (10) begin @(posedge i_clk); #1; end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge i_clk); #1;
    checks++; if (o_dvalid !== 1'b0) begin failures++; $display("FAIL reset_dvalid got=%b exp=0", o_dvalid); end
    checks++; if (o_data !== '0) begin failures++; $display("FAIL reset_data got=%0d exp=0", o_data); end
    checks++; if (o_in_rdy !== 1'b1) begin failures++; $display("FAIL reset_in_rdy got=%b exp=1", o_in_rdy); end
    checks++; if (o_frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", o_frame_done); end
    reset = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_passthrough();
    tx_mode = 0; got.delete(); exp_q.delete();
    fd_cnt = 0; first_valid_cyc = -1;
    add_expected(ramp, 0, 0, 0);
    run_frame(ramp, NPIX, 2'd0, 1'b0, 1'b0);
    wait_outputs(exp_q.size());
    checks++; if (got.size() !== exp_q.size()) begin failures++; $display("FAIL pass_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL pass[%0d] got=%0d exp=%0d", i, got[i], exp_q[i]); end
    end
    checks++; if (fd_cnt !== 1) begin failures++; $display("FAIL frame_done_pulses got=%0d exp=1", fd_cnt); end
    checks++; if (fd_after_last !== 1'b1) begin failures++; $display("FAIL frame_done_timing got=%b exp=1", fd_after_last); end
    checks++; if (first_valid_cyc - acc12_cyc !== 2) begin failures++; $display("FAIL latency got=%0d exp=2", first_valid_cyc - acc12_cyc); end
  endtask

  task automatic test_gauss();
    tx_mode = 0; got.delete(); exp_q.delete();
    foreach (flat[i]) flat[i] = 100;
    add_expected(flat, 1, 0, 0);
    run_frame(flat, NPIX, 2'd1, 1'b0, 1'b0);
    foreach (flat[i]) flat[i] = 255;
    add_expected(flat, 1, 0, 0);
    run_frame(flat, NPIX, 2'd1, 1'b0, 1'b0);
    wait_outputs(exp_q.size());
    checks++; if (got.size() !== exp_q.size()) begin failures++; $display("FAIL gauss_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL gauss[%0d] got=%0d exp=%0d", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_sharpen_laplace();
    tx_mode = 0; got.delete(); exp_q.delete();
    add_expected(img3, 2, 0, 0);
    run_frame(img3, NPIX, 2'd2, 1'b0, 1'b0);
    add_expected(img3, 3, 0, 0);
    run_frame(img3, NPIX, 2'd3, 1'b0, 1'b0);
    wait_outputs(exp_q.size());
    checks++; if (got.size() !== exp_q.size()) begin failures++; $display("FAIL edge_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL edge[%0d] got=%0d exp=%0d", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    tx_mode = 1; @(posedge i_clk); #1;
    got.delete(); exp_q.delete(); acc_cnt = 0;
    add_expected(ramp, 0, 0, 0);
    fork
      run_frame(ramp, NPIX, 2'd0, 1'b0, 1'b0);
      begin
        repeat (60) @(posedge i_clk); #1;
        checks++; if (o_in_rdy !== 1'b0) begin failures++; $display("FAIL bp_in_rdy got=%b exp=0", o_in_rdy); end
        checks++; if (acc_cnt !== 18) begin failures++; $display("FAIL bp_accepted got=%0d exp=18", acc_cnt); end
        checks++; if (o_dvalid !== 1'b1) begin failures++; $display("FAIL bp_dvalid got=%b exp=1", o_dvalid); end
        checks++; if (got.size() !== 0) begin failures++; $display("FAIL bp_popped got=%0d exp=0", got.size()); end
        tx_mode = 0;
      end
    join
    wait_outputs(exp_q.size());
    checks++; if (got.size() !== exp_q.size()) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL bp[%0d] got=%0d exp=%0d", i, got[i], exp_q[i]); end
    end
    tx_mode = 2; got.delete(); exp_q.delete();
    add_expected(ramp, 0, 0, 0);
    run_frame(ramp, NPIX, 2'd0, 1'b0, 1'b0);
    wait_outputs(exp_q.size());
    checks++; if (got.size() !== exp_q.size()) begin failures++; $display("FAIL toggle_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL toggle[%0d] got=%0d exp=%0d", i, got[i], exp_q[i]); end
    end
    tx_mode = 0;
  endtask

  task automatic test_reset_midframe();
    tx_mode = 1; @(posedge i_clk); #1;
    got.delete(); exp_q.delete();
    run_frame(ramp, 14, 2'd0, 1'b0, 1'b0);
    repeat (4) begin @(posedge i_clk); #1; end
    checks++; if (o_dvalid !== 1'b1) begin failures++; $display("FAIL pre_reset_dvalid got=%b exp=1", o_dvalid); end
    reset = 1'b0; #1;
    checks++; if (o_dvalid !== 1'b0) begin failures++; $display("FAIL async_reset_dvalid got=%b exp=0", o_dvalid); end
    checks++; if (o_in_rdy !== 1'b1) begin failures++; $display("FAIL async_reset_in_rdy got=%b exp=1", o_in_rdy); end
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    checks++; if (o_dvalid !== 1'b0) begin failures++; $display("FAIL held_reset_dvalid got=%b exp=0", o_dvalid); end
    reset = 1'b1; tx_mode = 0;
    @(posedge i_clk); #1;
    got.delete();
    add_expected(ramp, 0, 0, 0);
    run_frame(ramp, NPIX, 2'd0, 1'b0, 1'b0);
    wait_outputs(exp_q.size());
    checks++; if (got.size() !== exp_q.size()) begin failures++; $display("FAIL rst_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL rst[%0d] got=%0d exp=%0d", i, got[i], exp_q[i]); end
    end
  endtask

`ifdef FILTRE_ESIK_EN
  task automatic test_thresh();
    tx_mode = 0; got.delete(); exp_q.delete();
    i_thresh = 8'd10; i_thresh_on = 1'b1;
    add_expected(img3, 2, 1, 10);
    run_frame(img3, NPIX, 2'd2, 1'b0, 1'b0);
    i_thresh_on = 1'b0;
    add_expected(img3, 2, 0, 0);
    run_frame(img3, NPIX, 2'd2, 1'b0, 1'b0);
    wait_outputs(exp_q.size());
    checks++; if (got.size() !== exp_q.size()) begin failures++; $display("FAIL thr_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL thr[%0d] got=%0d exp=%0d", i, got[i], exp_q[i]); end
    end
  endtask
`endif

  task automatic test_random();
    int img[NPIX];
    got.delete(); exp_q.delete();
    tx_mode = 3;
    for (int f = 0; f < 6; f++) begin
      logic [1:0] m;
      m = 2'($urandom_range(0, 3));
      foreach (img[i]) img[i] = $urandom_range(0, 255);
      add_expected(img, int'(m), 0, 0);
      run_frame(img, NPIX, m, 1'b1, 1'b1);
    end
    tx_mode = 0;
    wait_outputs(exp_q.size());
    checks++; if (got.size() !== exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL rand[%0d] got=%0d exp=%0d", i, got[i], exp_q[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) begin
      ramp[i] = i;
      img3[i] = (i == 7) ? 50 : 10;
    end
    test_reset();
    test_passthrough();
    test_gauss();
    test_sharpen_laplace();
    test_backpressure();
    test_reset_midframe();
`ifdef FILTRE_ESIK_EN
    test_thresh();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
